dmem_responder: RTL and testbench

- Data-memory responder on the far side of the SEQ memory stage's load/store interface.
- Accepts one 64-bit read or write request at a time over a valid/ready handshake.
- Holds it for a fixed latency, performs the byte-addressed little-endian access, and returns read data plus an error flag over a second valid/ready handshake.
- Replaces the zero-latency array, so the memory stage can be exercised against realistic stalls and dmem_error generation.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes, default
// store size and the Y86 icodes the memory stage uses to derive req_write.
package dmem_pkg;

  localparam int DMEM_BYTES_DEFAULT = 8192;

  typedef logic [1:0] dmem_state_t;
  localparam dmem_state_t ST_IDLE = 2'd0;
  localparam dmem_state_t ST_BUSY = 2'd1;
  localparam dmem_state_t ST_RESP = 2'd2;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Stores are the instructions that push or write a register to memory.
  function automatic logic icode_is_store(logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the memory stage (master) and
// the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_array.sv
// Byte-wide data store with one 8-byte little-endian read port and one
// 8-byte write port; byte i of the word lives at addr+i.
module dmem_array import dmem_pkg::*; #(
  parameter int MEM_BYTES = DMEM_BYTES_DEFAULT,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[addr + AW'(i)];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) mem[addr + AW'(i)] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one 64-bit load/store in flight.
// Define DMEM_ALIGN_CHECK_EN to also fault on addresses that are not 8-byte aligned.
module dmem_responder import dmem_pkg::*; #(
  parameter int MEM_BYTES = DMEM_BYTES_DEFAULT,
  parameter int LATENCY   = 2,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        acc_err;
  logic        fire;
  logic [63:0] arr_rdata;

  // Full 64-bit bounds compare so huge addresses never alias into the store.
  always_comb begin
    acc_err = addr_q > 64'(MEM_BYTES - 8);
`ifdef DMEM_ALIGN_CHECK_EN
    acc_err = acc_err | (addr_q[2:0] != 3'd0);
`endif
  end

  assign fire = (state == ST_BUSY) && (cnt == 4'd0);

  dmem_array #(.MEM_BYTES(MEM_BYTES)) u_array (
    .clk   (clk),
    .we    (fire && wr_q && !acc_err),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt     <= 4'(LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            state   <= ST_RESP;
            err_q   <= acc_err;
            rdata_q <= (wr_q || acc_err) ? 64'd0 : arr_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state   <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-level memory model plus per-cycle
// output checks, with literal expectations on selected responses.
module tb_dmem_responder;
  localparam int MEM_BYTES = 8192;
  localparam int LAT       = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dmem_if bus();

  dmem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  longint unsigned cyc = 0;
  int naccept = 0;
  int nresp   = 0;
  logic [63:0] dut_rd;
  logic        dut_err;

  logic [7:0] mdl [longint unsigned];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mdl_read(input logic [63:0] a);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = mdl.exists(a + 64'(i)) ? mdl[a + 64'(i)] : 8'h00;
    return r;
  endfunction

  function automatic bit mdl_err(input logic [63:0] a);
    bit e = (a > 64'(MEM_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    e = e || (a[2:0] != 3'd0);
`endif
    return e;
  endfunction

  // Per-cycle compare against the transaction-level model.
  initial begin : monitor
    bit pend = 0, committed = 0, ev, do_acc, do_rsp;
    bit e_wr, e_err, n_wr;
    longint unsigned acc = 0;
    logic [63:0] e_rd = '0, e_a = '0, e_d = '0, n_a, n_d;
    forever begin
      @(negedge clk);
      ev = 0;
      if (cyc > 0) begin
        if (reset) begin
          chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
          chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end else begin
          ev = pend && (cyc >= acc + LAT);
          chk("req_ready", 64'(bus.req_ready), 64'(!pend));
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
          chk("rsp_rdata", bus.rsp_rdata, ev ? e_rd : 64'd0);
          chk("rsp_error", 64'(bus.rsp_error), ev ? 64'(e_err) : 64'd0);
          if (ev && !committed) begin
            committed = 1;
            if (e_wr && !e_err)
              for (int i = 0; i < 8; i++) mdl[e_a + 64'(i)] = e_d[8*i +: 8];
          end
        end
      end
      do_acc = !reset && !pend && bus.req_valid;
      do_rsp = !reset && ev && bus.rsp_ready;
      n_wr = bus.req_write; n_a = bus.req_addr; n_d = bus.req_wdata;
      if (do_rsp) begin dut_rd = bus.rsp_rdata; dut_err = bus.rsp_error; end
      @(posedge clk);
      cyc++;
      if (reset) pend = 0;
      else if (do_rsp) begin pend = 0; nresp++; end
      else if (do_acc) begin
        pend = 1; committed = 0; acc = cyc; naccept++;
        e_wr = n_wr; e_a = n_a; e_d = n_d;
        e_err = mdl_err(n_a);
        e_rd = (n_wr || e_err) ? 64'd0 : mdl_read(n_a);
      end
    end
  end

  task automatic txn(input bit w, input logic [63:0] a, input logic [63:0] d,
                     input int hold, input bit keep_valid);
    int a0 = naccept, r0 = nresp, t;
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    bus.rsp_ready = (hold == 0);
    t = 0;
    while (naccept == a0 && t < 20) begin @(posedge clk); #1; t++; end
    chk("accept_seen", 64'(naccept - a0), 64'd1);
    if (!keep_valid) bus.req_valid = 0;
    bus.req_addr = ~a; bus.req_wdata = ~d;
    t = 0;
    while (!bus.rsp_valid && nresp == r0 && t < 40) begin @(posedge clk); #1; t++; end
    repeat (hold) begin @(posedge clk); #1; end
    bus.rsp_ready = 1;
    t = 0;
    while (nresp == r0 && t < 40) begin @(posedge clk); #1; t++; end
    bus.rsp_ready = 0; bus.req_valid = 0;
    repeat (2) @(posedge clk);
    #1 chk("one_resp", 64'(nresp - r0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
    chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("idle_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("idle_rsp_error", 64'(bus.rsp_error), 64'd0);

    txn(1, 64'h108, 64'h0, 0, 0);
    txn(1, 64'h0, 64'hCAFE_F00D_DEAD_BEEF, 0, 0);
    txn(1, 64'h200, 64'h5555_6666_7777_8888, 0, 0);
    txn(1, 64'h1FF8, 64'h0F0E_0D0C_0B0A_0908, 0, 0);
    txn(1, 64'h100, 64'h1234_5678_90AB_CDEF, 0, 0);
    chk("wr100_err", 64'(dut_err), 64'd0);
    chk("wr100_rd", dut_rd, 64'd0);
    chk("mdl_pin_101", mdl_read(64'h101), 64'h0012_3456_7890_ABCD);

    txn(0, 64'h100, 64'h0, 0, 0);
    chk("rd100", dut_rd, 64'h1234_5678_90AB_CDEF);
    txn(0, 64'h101, 64'h0, 0, 0);
    chk("rd101", dut_rd, 64'h0012_3456_7890_ABCD);
    txn(0, 64'h1FF8, 64'h0, 0, 0);
    chk("rd1ff8_err", 64'(dut_err), 64'd0);
    chk("rd1ff8", dut_rd, 64'h0F0E_0D0C_0B0A_0908);
    txn(0, 64'h1FF9, 64'h0, 0, 0);
    chk("rd1ff9_err", 64'(dut_err), 64'd1);
    chk("rd1ff9", dut_rd, 64'd0);
    txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444, 0, 0);
    chk("wrff_err", 64'(dut_err), 64'd1);
    txn(0, 64'h0, 64'h0, 0, 0);
    chk("rd0_unchanged", dut_rd, 64'hCAFE_F00D_DEAD_BEEF);
    txn(0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 0, 0);
    chk("rdfff9_err", 64'(dut_err), 64'd1);

    // backpressure with req_valid held throughout
    txn(0, 64'h100, 64'h0, 5, 1);
    chk("bp_rd100", dut_rd, 64'h1234_5678_90AB_CDEF);

    // reset while the write is still counting down
    r0 = nresp;
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 64'h200;
    bus.req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge clk); #1;
    bus.req_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    repeat (6) @(posedge clk);
    #1 chk("rst_no_resp", 64'(nresp - r0), 64'd0);
    txn(0, 64'h200, 64'h0, 0, 0);
    chk("rd200_prior", dut_rd, 64'h5555_6666_7777_8888);

    txn(0, 64'h104, 64'h0, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("rd104_err", 64'(dut_err), 64'd1);
    chk("rd104", dut_rd, 64'd0);
`else
    chk("rd104_err", 64'(dut_err), 64'd0);
    chk("rd104", dut_rd, 64'h0000_0000_1234_5678);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
